cv32e40p_apu_arbiter: RTL and testbench

Shares one APU/FPU among NB_REQ core-side APU masters, such as multiple cv32e40p cores in a cluster. It does round-robin arbitration of requests and forwards the winner's operands, op and flags. It tracks the requester ID of every outstanding operation in an in-order ID FIFO and routes each response back to its originator. The shared APU returns results strictly in issue order.

---
 rtl/cv32e40p_apu_core_pkg.sv | 23 ++
 rtl/cv32e40p_apu_arb_id_fifo.sv | 62 ++++++
 rtl/cv32e40p_apu_arbiter.sv | 126 ++++++++++++
 tb/tb_cv32e40p_apu_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_apu_core_pkg.sv
// ---------------------------------------------------------------------------
// cv32e40p_apu_core_pkg
// Shared constants for the APU arbiter slice: default interface widths of a
// core-side APU port, default requester/outstanding counts, and a helper that
// turns a requester count into a requester-ID width.
// ---------------------------------------------------------------------------
package cv32e40p_apu_core_pkg;

  localparam int unsigned APU_NARGS_DEF       = 3;
  localparam int unsigned APU_WOP_DEF         = 6;
  localparam int unsigned APU_NDSFLAGS_DEF    = 15;
  localparam int unsigned APU_NUSFLAGS_DEF    = 5;
  localparam int unsigned NB_REQ_DEF          = 4;
  localparam int unsigned MAX_OUTSTANDING_DEF = 4;

  // Width needed to hold a requester ID; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned APU_ID_WIDTH = id_width(NB_REQ_DEF);

endpackage

// File: rtl/cv32e40p_apu_arb_id_fifo.sv
// ---------------------------------------------------------------------------
// cv32e40p_apu_arb_id_fifo
// In-order FIFO of requester IDs for operations issued to the shared APU.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i, data_i: store an ID (ignored while full)
//   pop_i         : drop the head entry (ignored while empty)
//   head_o        : ID of the oldest outstanding operation
//   count_o       : number of stored IDs (0..DEPTH)
//   full_o        : count_o == DEPTH
// ---------------------------------------------------------------------------
module cv32e40p_apu_arb_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q, count_d;
  logic               push_ok, pop_ok;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Simultaneous push and pop cancel out in the count.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) count_d = count_q + 1'b1;
    if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/cv32e40p_apu_arbiter.sv
// ---------------------------------------------------------------------------
// cv32e40p_apu_arbiter
// Shares one in-order APU among NB_REQ core-side APU masters. Requests are
// arbitrated round-robin, the winner's operands/op/flags are forwarded, and
// the ID of every accepted operation is queued so responses can be steered
// back to their originator. Result and flags are broadcast unregistered.
//   core_req_i/core_gnt_o           : per-requester handshake (same-cycle grant)
//   core_operands_i/op_i/flags_i    : per-requester request payload (flattened)
//   core_rvalid_o/result_o/rflags_o : response to requesters
//   apu_*                           : shared APU request/response port
//   busy_o                          : at least one operation outstanding
//   err_o                           : sticky, a response arrived with no owner
// ---------------------------------------------------------------------------
module cv32e40p_apu_arbiter
  import cv32e40p_apu_core_pkg::*;
#(
  parameter int unsigned NB_REQ          = NB_REQ_DEF,
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
  parameter int unsigned APU_NARGS       = APU_NARGS_DEF,
  parameter int unsigned APU_WOP         = APU_WOP_DEF,
  parameter int unsigned APU_NDSFLAGS    = APU_NDSFLAGS_DEF,
  parameter int unsigned APU_NUSFLAGS    = APU_NUSFLAGS_DEF
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NB_REQ-1:0]                   core_req_i,
  output logic [NB_REQ-1:0]                   core_gnt_o,
  input  logic [NB_REQ*APU_NARGS*32-1:0]      core_operands_i,
  input  logic [NB_REQ*APU_WOP-1:0]           core_op_i,
  input  logic [NB_REQ*APU_NDSFLAGS-1:0]      core_flags_i,
  output logic [NB_REQ-1:0]                   core_rvalid_o,
  output logic [31:0]                         core_result_o,
  output logic [APU_NUSFLAGS-1:0]             core_rflags_o,
  output logic                                apu_req_o,
  input  logic                                apu_gnt_i,
  output logic [APU_NARGS*32-1:0]             apu_operands_o,
  output logic [APU_WOP-1:0]                  apu_op_o,
  output logic [APU_NDSFLAGS-1:0]             apu_flags_o,
  input  logic                                apu_rvalid_i,
  input  logic [31:0]                         apu_result_i,
  input  logic [APU_NUSFLAGS-1:0]             apu_rflags_i,
  output logic                                busy_o,
  output logic                                err_o
);

  localparam int unsigned ID_W  = id_width(NB_REQ);
  localparam int unsigned OPS_W = APU_NARGS * 32;

  logic [ID_W-1:0]              rr_q, rr_d, sel, head;
  logic [$clog2(MAX_OUTSTANDING):0] count;
  logic                         full, any_req, accept, empty;
  logic                         bypass, pop, push, orphan;
  logic                         err_q;

  // Scan from the highest cyclic offset down so the lowest offset from rr_q
  // wins; this keeps a nacked requester selected until someone ahead of it
  // raises req.
  always_comb begin
    sel = rr_q;
    for (int k = int'(NB_REQ) - 1; k >= 0; k--) begin
      if (core_req_i[(int'(rr_q) + k) % int'(NB_REQ)])
        sel = ID_W'((int'(rr_q) + k) % int'(NB_REQ));
    end
  end

  assign any_req   = |core_req_i;
  assign apu_req_o = any_req & ~full;
  assign accept    = apu_req_o & apu_gnt_i;
  assign empty     = (count == '0);

  // A response with an empty FIFO can only belong to the operation accepted
  // in this very cycle; otherwise nobody owns it.
  assign bypass = empty & apu_rvalid_i & accept;
  assign orphan = empty & apu_rvalid_i & ~accept;
  assign pop    = ~empty & apu_rvalid_i;
  assign push   = accept & ~bypass;

  // Payload is zeroed when no request is presented so idle outputs are quiet.
  assign apu_operands_o = apu_req_o ? core_operands_i[int'(sel)*OPS_W +: OPS_W] : '0;
  assign apu_op_o       = apu_req_o ? core_op_i[int'(sel)*APU_WOP +: APU_WOP] : '0;
  assign apu_flags_o    = apu_req_o ? core_flags_i[int'(sel)*APU_NDSFLAGS +: APU_NDSFLAGS] : '0;

  always_comb begin
    core_gnt_o    = '0;
    core_rvalid_o = '0;
    if (accept) core_gnt_o[sel] = 1'b1;
    if (pop)         core_rvalid_o[head] = 1'b1;
    else if (bypass) core_rvalid_o[sel]  = 1'b1;
  end

  assign core_result_o = apu_result_i;
  assign core_rflags_o = apu_rflags_i;
  assign busy_o        = ~empty;
  assign err_o         = err_q;

  always_comb begin
    rr_d = rr_q;
    if (accept) rr_d = (int'(sel) == int'(NB_REQ) - 1) ? '0 : sel + 1'b1;
  end

  // Round-robin pointer and sticky orphan-response flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q  <= '0;
      err_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
      if (orphan) err_q <= 1'b1;
    end
  end

  cv32e40p_apu_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ID_W)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (sel),
    .head_o  (head),
    .count_o (count),
    .full_o  (full)
  );

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cv32e40p_apu_arbiter
// Directed vector bench for the shared-APU arbiter. Each vector is one clock
// cycle: inputs are driven just after the rising edge and outputs compared on
// the falling edge, before the next edge commits state.
// ---------------------------------------------------------------------------
module tb_cv32e40p_apu_arbiter;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [3:0]    core_req_i;
  logic [3:0]    core_gnt_o;
  logic [383:0]  core_operands_i;
  logic [23:0]   core_op_i;
  logic [59:0]   core_flags_i;
  logic [3:0]    core_rvalid_o;
  logic [31:0]   core_result_o;
  logic [4:0]    core_rflags_o;
  logic          apu_req_o;
  logic          apu_gnt_i;
  logic [95:0]   apu_operands_o;
  logic [5:0]    apu_op_o;
  logic [14:0]   apu_flags_o;
  logic          apu_rvalid_i;
  logic [31:0]   apu_result_i;
  logic [4:0]    apu_rflags_i;
  logic          busy_o;
  logic          err_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] res;
    logic [3:0]  eGnt;
    logic        eReq;
    int          eSel;
    logic [3:0]  eRv;
    logic        eBusy;
    logic        eErr;
  } vecT;

  vecT vecs[$];

  cv32e40p_apu_arbiter dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .core_req_i      (core_req_i),
    .core_gnt_o      (core_gnt_o),
    .core_operands_i (core_operands_i),
    .core_op_i       (core_op_i),
    .core_flags_i    (core_flags_i),
    .core_rvalid_o   (core_rvalid_o),
    .core_result_o   (core_result_o),
    .core_rflags_o   (core_rflags_o),
    .apu_req_o       (apu_req_o),
    .apu_gnt_i       (apu_gnt_i),
    .apu_operands_o  (apu_operands_o),
    .apu_op_o        (apu_op_o),
    .apu_flags_o     (apu_flags_o),
    .apu_rvalid_i    (apu_rvalid_i),
    .apu_result_i    (apu_result_i),
    .apu_rflags_i    (apu_rflags_i),
    .busy_o          (busy_o),
    .err_o           (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Distinct payload per requester so the forwarded fields identify the winner.
  function automatic logic [95:0] opsOf(input int i);
    logic [95:0] v;
    for (int j = 0; j < 3; j++) v[j*32 +: 32] = 32'hA000_0000 | 32'(i << 8) | 32'(j);
    return v;
  endfunction

  function automatic logic [5:0] opOf(input int i);
    return 6'(i + 1);
  endfunction

  function automatic logic [14:0] flagsOf(input int i);
    return 15'(i * 5 + 3);
  endfunction

  task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic [3:0] req, input logic gnt, input logic rv,
                        input logic [31:0] res, input logic [3:0] eGnt, input logic eReq,
                        input int eSel, input logic [3:0] eRv, input logic eBusy,
                        input logic eErr);
    vecT v;
    v.req = req; v.gnt = gnt; v.rv = rv; v.res = res; v.eGnt = eGnt;
    v.eReq = eReq; v.eSel = eSel; v.eRv = eRv; v.eBusy = eBusy; v.eErr = eErr;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vecT v);
    @(posedge clk_i);
    #1;
    core_req_i   = v.req;
    apu_gnt_i    = v.gnt;
    apu_rvalid_i = v.rv;
    apu_result_i = v.res;
    apu_rflags_i = 5'(v.res);
  endtask

  task automatic checkOutput(input vecT v, input int n);
    @(negedge clk_i);
    checkVal($sformatf("gnt[%0d]", n), 128'(core_gnt_o), 128'(v.eGnt));
    checkVal($sformatf("apu_req[%0d]", n), 128'(apu_req_o), 128'(v.eReq));
    checkVal($sformatf("rvalid[%0d]", n), 128'(core_rvalid_o), 128'(v.eRv));
    checkVal($sformatf("busy[%0d]", n), 128'(busy_o), 128'(v.eBusy));
    checkVal($sformatf("err[%0d]", n), 128'(err_o), 128'(v.eErr));
    if (v.eReq) begin
      checkVal($sformatf("operands[%0d]", n), 128'(apu_operands_o), 128'(opsOf(v.eSel)));
      checkVal($sformatf("op[%0d]", n), 128'(apu_op_o), 128'(opOf(v.eSel)));
      checkVal($sformatf("flags[%0d]", n), 128'(apu_flags_o), 128'(flagsOf(v.eSel)));
    end
    if (v.eRv != 4'b0000) begin
      checkVal($sformatf("result[%0d]", n), 128'(core_result_o), 128'(v.res));
      checkVal($sformatf("rflags[%0d]", n), 128'(core_rflags_o), 128'(5'(v.res)));
    end
  endtask

  initial begin
    vecT v;
    rst_ni       = 1'b0;
    core_req_i   = '0;
    apu_gnt_i    = 1'b0;
    apu_rvalid_i = 1'b0;
    apu_result_i = '0;
    apu_rflags_i = '0;
    for (int i = 0; i < 4; i++) begin
      core_operands_i[i*96 +: 96] = opsOf(i);
      core_op_i[i*6 +: 6]         = opOf(i);
      core_flags_i[i*15 +: 15]    = flagsOf(i);
    end

    #12;
    checkVal("reset gnt", 128'(core_gnt_o), 128'(0));
    checkVal("reset apu_req", 128'(apu_req_o), 128'(0));
    checkVal("reset rvalid", 128'(core_rvalid_o), 128'(0));
    checkVal("reset operands", 128'(apu_operands_o), 128'(0));
    checkVal("reset op", 128'(apu_op_o), 128'(0));
    checkVal("reset flags", 128'(apu_flags_o), 128'(0));
    checkVal("reset busy", 128'(busy_o), 128'(0));
    checkVal("reset err", 128'(err_o), 128'(0));
    #8;
    rst_ni = 1'b1;

    // Four back-to-back grants in round-robin order fill the ID FIFO.
    addVec(4'b1111, 1, 0, 0, 4'b0001, 1, 0, 4'b0000, 0, 0);
    addVec(4'b1111, 1, 0, 0, 4'b0010, 1, 1, 4'b0000, 1, 0);
    addVec(4'b1111, 1, 0, 0, 4'b0100, 1, 2, 4'b0000, 1, 0);
    addVec(4'b1111, 1, 0, 0, 4'b1000, 1, 3, 4'b0000, 1, 0);
    addVec(4'b1111, 1, 0, 0, 4'b0000, 0, 0, 4'b0000, 1, 0);
    // Full with a response: still no request this cycle.
    addVec(4'b1111, 1, 1, 32'h11, 4'b0000, 0, 0, 4'b0001, 1, 0);
    addVec(4'b0000, 0, 1, 32'h22, 4'b0000, 0, 0, 4'b0010, 1, 0);
    addVec(4'b0000, 0, 1, 32'h33, 4'b0000, 0, 0, 4'b0100, 1, 0);
    addVec(4'b0000, 0, 1, 32'h44, 4'b0000, 0, 0, 4'b1000, 1, 0);
    addVec(4'b0000, 0, 0, 0,      4'b0000, 0, 0, 4'b0000, 0, 0);
    // Nack for three cycles keeps requester 0 selected with stable payload.
    addVec(4'b0101, 0, 0, 0, 4'b0000, 1, 0, 4'b0000, 0, 0);
    addVec(4'b0101, 0, 0, 0, 4'b0000, 1, 0, 4'b0000, 0, 0);
    addVec(4'b0101, 0, 0, 0, 4'b0000, 1, 0, 4'b0000, 0, 0);
    addVec(4'b0101, 1, 0, 0, 4'b0001, 1, 0, 4'b0000, 0, 0);
    addVec(4'b0101, 1, 0, 0, 4'b0100, 1, 2, 4'b0000, 1, 0);
    addVec(4'b0000, 0, 1, 32'h55, 4'b0000, 0, 0, 4'b0001, 1, 0);
    addVec(4'b0000, 0, 1, 32'h66, 4'b0000, 0, 0, 4'b0100, 1, 0);
    addVec(4'b0000, 0, 0, 0,      4'b0000, 0, 0, 4'b0000, 0, 0);
    // Issue 2, 0, 3 then return A, B, C in order.
    addVec(4'b0100, 1, 0, 0, 4'b0100, 1, 2, 4'b0000, 0, 0);
    addVec(4'b0001, 1, 0, 0, 4'b0001, 1, 0, 4'b0000, 1, 0);
    addVec(4'b1000, 1, 0, 0, 4'b1000, 1, 3, 4'b0000, 1, 0);
    addVec(4'b0000, 0, 1, 32'hA, 4'b0000, 0, 0, 4'b0100, 1, 0);
    addVec(4'b0000, 0, 1, 32'hB, 4'b0000, 0, 0, 4'b0001, 1, 0);
    addVec(4'b0000, 0, 1, 32'hC, 4'b0000, 0, 0, 4'b1000, 1, 0);
    addVec(4'b0000, 0, 0, 0,     4'b0000, 0, 0, 4'b0000, 0, 0);
    // Push and pop together: response goes to 1, head becomes 3.
    addVec(4'b0010, 1, 0, 0,     4'b0010, 1, 1, 4'b0000, 0, 0);
    addVec(4'b1000, 1, 1, 32'hD, 4'b1000, 1, 3, 4'b0010, 1, 0);
    addVec(4'b0000, 0, 1, 32'hE, 4'b0000, 0, 0, 4'b1000, 1, 0);
    addVec(4'b0000, 0, 0, 0,     4'b0000, 0, 0, 4'b0000, 0, 0);
    // Empty FIFO bypass: same-cycle response to requester 2, no push.
    addVec(4'b0100, 1, 1, 32'hF, 4'b0100, 1, 2, 4'b0100, 0, 0);
    addVec(4'b0000, 0, 0, 0,     4'b0000, 0, 0, 4'b0000, 0, 0);
    // Orphan response: dropped, err rises next cycle and sticks.
    addVec(4'b0000, 0, 1, 32'h77, 4'b0000, 0, 0, 4'b0000, 0, 0);
    addVec(4'b0000, 0, 0, 0,      4'b0000, 0, 0, 4'b0000, 0, 1);
    addVec(4'b0000, 0, 0, 0,      4'b0000, 0, 0, 4'b0000, 0, 1);

    foreach (vecs[n]) begin
      applyStimulus(vecs[n]);
      checkOutput(vecs[n], n);
    end

    // Reset while an operation is outstanding discards its ID; the late
    // response afterwards has no owner.
    v.req = 4'b0010; v.gnt = 1; v.rv = 0; v.res = 0; v.eGnt = 4'b0010;
    v.eReq = 1; v.eSel = 1; v.eRv = 4'b0000; v.eBusy = 0; v.eErr = 1;
    applyStimulus(v);
    checkOutput(v, 100);
    @(posedge clk_i);
    #1;
    core_req_i = '0;
    apu_gnt_i  = 1'b0;
    #1;
    checkVal("busy before reset", 128'(busy_o), 128'(1));
    rst_ni = 1'b0;
    #1;
    checkVal("busy in reset", 128'(busy_o), 128'(0));
    checkVal("err in reset", 128'(err_o), 128'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    apu_rvalid_i = 1'b1;
    apu_result_i = 32'h99;
    @(negedge clk_i);
    checkVal("late rvalid", 128'(core_rvalid_o), 128'(0));
    checkVal("late err before edge", 128'(err_o), 128'(0));
    @(posedge clk_i);
    #1;
    apu_rvalid_i = 1'b0;
    @(negedge clk_i);
    checkVal("late err", 128'(err_o), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
